// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding used by both uart_tx and uart_rx,
// frame data width and the even-parity helper.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    START  = 3'b010,
    DATAIN = 3'b011,
    STOP   = 3'b100,
    CLEAN  = 3'b101,
    PARITY = 3'b110
  } uart_state_t;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side UART bundle: serial line in, recovered byte and status strobes out.
// master = the receiver, slave = the game/keypad logic plus whatever drives the line.
interface uart_rx_if;
  import uart_pkg::*;

  logic                 rx_serial;
  logic [DATA_BITS-1:0] rx_byte;
  logic                 rx_ready;
  logic                 rx_busy;
  logic                 framing_err;
  logic                 parity_err;

  modport master (
    input  rx_serial,
    output rx_byte,
    output rx_ready,
    output rx_busy,
    output framing_err,
    output parity_err
  );

  modport slave (
    output rx_serial,
    input  rx_byte,
    input  rx_ready,
    input  rx_busy,
    input  framing_err,
    input  parity_err
  );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs; both flops reset
// to RESET_VAL with a synchronous active-low reset.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic nRst,
  input  logic d,
  output logic q
);

  logic sync1;

  always_ff @(posedge clk) begin
    if (!nRst) begin
      sync1 <= RESET_VAL;
      q     <= RESET_VAL;
    end else begin
      sync1 <= d;
      q     <= sync1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 8N1 by default, 8E1 when UART_PARITY_EN is defined.
// CLKS_PER_BIT must be even and >= 4.
//
//   state  | meaning
//   IDLE   | line idle, waiting for a falling edge on sync2
//   START  | timing to start-bit midpoint; high there means a glitch
//   DATAIN | sampling 8 data bits LSB first, one per bit period
//   PARITY | sampling even-parity bit (UART_PARITY_EN only)
//   STOP   | sampling stop bit, issuing ready / error strobes
//   CLEAN  | line held low after a framing error; wait for idle high
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic      clk,
  input  logic      nRst,
  uart_rx_if.master rx
);

  localparam int H      = CLKS_PER_BIT / 2;
  localparam int CW     = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(DATA_BITS);

  localparam logic [CW-1:0]    HALF_LAST = CW'(H - 1);
  localparam logic [CW-1:0]    BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic                 sync2;
  uart_state_t          state;
  logic [CW-1:0]        cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] byte_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 ferr_q;
`ifdef UART_PARITY_EN
  logic                 par_mismatch;
  logic                 perr_q;
`endif

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk  (clk),
    .nRst (nRst),
    .d    (rx.rx_serial),
    .q    (sync2)
  );

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      byte_q       <= '0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      ferr_q       <= 1'b0;
`ifdef UART_PARITY_EN
      par_mismatch <= 1'b0;
      perr_q       <= 1'b0;
`endif
    end else begin
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
      perr_q  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!sync2) begin
            state  <= START;
            busy_q <= 1'b1;
          end
        end

        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!sync2) begin
              state   <= DATAIN;
              bit_idx <= '0;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATAIN: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shift   <= {sync2, shift[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == IDX_LAST) begin
`ifdef UART_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

`ifdef UART_PARITY_EN
        PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt          <= '0;
            par_mismatch <= sync2 ^ even_parity(shift);
            state        <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif

        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (sync2) begin
              state  <= IDLE;
              busy_q <= 1'b0;
`ifdef UART_PARITY_EN
              if (par_mismatch) begin
                perr_q <= 1'b1;
              end else begin
                byte_q  <= shift;
                ready_q <= 1'b1;
              end
`else
              byte_q  <= shift;
              ready_q <= 1'b1;
`endif
            end else begin
              // Line still low at stop: treat as break and wait it out in CLEAN
              state  <= CLEAN;
              ferr_q <= 1'b1;
`ifdef UART_PARITY_EN
              perr_q <= par_mismatch;
`endif
            end
`ifdef UART_PARITY_EN
            par_mismatch <= 1'b0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        CLEAN: begin
          if (sync2) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

  assign rx.rx_byte     = byte_q;
  assign rx.rx_ready    = ready_q;
  assign rx.rx_busy     = busy_q;
  assign rx.framing_err = ferr_q;
`ifdef UART_PARITY_EN
  assign rx.parity_err  = perr_q;
`else
  assign rx.parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a table of frames plus hand-written glitch,
// break, back-to-back and mid-frame reset sequences.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 16;
  localparam int H   = CPB / 2;
`ifdef UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  // bit periods from start edge to stop sample
  localparam int NFR = PAR_EN ? 10 : 9;
  // edge at which a posedge sampler first sees rx_ready high
  localparam int READY_OFS = 2 + H + NFR * CPB + 1;

  typedef struct {
    logic [7:0] data;
    bit         stop_bit;
    bit         par_wrong;
    int         exp_ready;
    int         exp_ferr;
    int         exp_perr;
    logic [7:0] exp_byte;
  } vec_t;

  logic tb_clk = 1'b0;
  logic nRst   = 1'b0;
  always #5 tb_clk = ~tb_clk;

  uart_rx_if rx_if ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk  (tb_clk),
    .nRst (nRst),
    .rx   (rx_if)
  );

  int cyc = 0;
  always @(posedge tb_clk) cyc <= cyc + 1;

  int         ready_cnt = 0;
  int         ferr_cnt  = 0;
  int         perr_cnt  = 0;
  int         combo_bad = 0;
  int         last_ready_edge = 0;
  logic [7:0] ready_bytes[$];

  always @(negedge tb_clk) begin
    if (rx_if.rx_ready === 1'b1) begin
      ready_cnt++;
      last_ready_edge = cyc + 1;
      ready_bytes.push_back(rx_if.rx_byte);
    end
    if (rx_if.framing_err === 1'b1) ferr_cnt++;
    if (rx_if.parity_err === 1'b1) perr_cnt++;
    if (rx_if.rx_ready === 1'b1 && (rx_if.framing_err === 1'b1 || rx_if.parity_err === 1'b1))
      combo_bad++;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_bit, input bit par_wrong,
                            output int t0);
    @(negedge tb_clk);
    rx_if.rx_serial = 1'b0;
    t0 = cyc + 1;
    repeat (CPB) @(negedge tb_clk);
    for (int i = 0; i < 8; i++) begin
      rx_if.rx_serial = d[i];
      repeat (CPB) @(negedge tb_clk);
    end
    if (PAR_EN) begin
      rx_if.rx_serial = (^d) ^ par_wrong;
      repeat (CPB) @(negedge tb_clk);
    end
    rx_if.rx_serial = stop_bit;
    repeat (CPB) @(negedge tb_clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t       vecs[8];
  int         n_vec;
  int         t0;
  int         r0, f0, p0;
  logic [7:0] cur_byte;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1, 0, 0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 1'b0, 1, 0, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 1'b0, 1, 0, 0, 8'hFF};
    vecs[3] = '{8'h5A, 1'b0, 1'b0, 0, 1, 0, 8'hFF};
    vecs[4] = '{8'h80, 1'b1, 1'b0, 1, 0, 0, 8'h80};
    vecs[5] = '{8'h9D, 1'b1, 1'b0, 1, 0, 0, 8'h9D};
    vecs[6] = '{8'h9D, 1'b1, 1'b1, 0, 0, 1, 8'h9D};
    vecs[7] = '{8'h42, 1'b0, 1'b1, 0, 1, 1, 8'h9D};
    n_vec = PAR_EN ? 8 : 5;

    // reset with the line low
    rx_if.rx_serial = 1'b0;
    nRst = 1'b0;
    repeat (2) @(negedge tb_clk);
    check("rst_byte",  rx_if.rx_byte, 8'h00);
    check("rst_ready", rx_if.rx_ready, 1'b0);
    check("rst_busy",  rx_if.rx_busy, 1'b0);
    check("rst_ferr",  rx_if.framing_err, 1'b0);
    check("rst_perr",  rx_if.parity_err, 1'b0);
    nRst = 1'b1;
    rx_if.rx_serial = 1'b1;
    repeat (20) @(negedge tb_clk);
    check("post_rst_pulses", ready_cnt + ferr_cnt + perr_cnt, 0);
    check("post_rst_busy", rx_if.rx_busy, 1'b0);
    cur_byte = 8'h00;

    for (int v = 0; v < n_vec; v++) begin
      r0 = ready_cnt; f0 = ferr_cnt; p0 = perr_cnt;
      send_frame(vecs[v].data, vecs[v].stop_bit, vecs[v].par_wrong, t0);
      rx_if.rx_serial = 1'b1;
      repeat (20) @(negedge tb_clk);
      check($sformatf("vec%0d_ready", v), ready_cnt - r0, vecs[v].exp_ready);
      check($sformatf("vec%0d_ferr", v),  ferr_cnt - f0,  vecs[v].exp_ferr);
      check($sformatf("vec%0d_perr", v),  perr_cnt - p0,  vecs[v].exp_perr);
      check($sformatf("vec%0d_byte", v),  rx_if.rx_byte,  vecs[v].exp_byte);
      check($sformatf("vec%0d_busy", v),  rx_if.rx_busy,  1'b0);
      if (vecs[v].exp_ready == 1)
        check($sformatf("vec%0d_ready_edge", v), last_ready_edge - t0, READY_OFS);
      cur_byte = vecs[v].exp_byte;
    end

    // glitch: 3 cycles low then high
    r0 = ready_cnt; f0 = ferr_cnt; p0 = perr_cnt;
    @(negedge tb_clk);
    rx_if.rx_serial = 1'b0;
    repeat (3) @(negedge tb_clk);
    check("glitch_busy_seen", rx_if.rx_busy, 1'b1);
    rx_if.rx_serial = 1'b1;
    repeat (20) @(negedge tb_clk);
    check("glitch_busy", rx_if.rx_busy, 1'b0);
    check("glitch_pulses", (ready_cnt - r0) + (ferr_cnt - f0) + (perr_cnt - p0), 0);
    check("glitch_byte", rx_if.rx_byte, cur_byte);

    // break: 3C with stop low, line held low 40 more cycles
    r0 = ready_cnt; f0 = ferr_cnt; p0 = perr_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, t0);
    repeat (40) @(negedge tb_clk);
    check("brk_busy_low_line", rx_if.rx_busy, 1'b1);
    check("brk_ferr", ferr_cnt - f0, 1);
    rx_if.rx_serial = 1'b1;
    repeat (5) @(negedge tb_clk);
    check("brk_busy_released", rx_if.rx_busy, 1'b0);
    repeat (200) @(negedge tb_clk);
    check("brk_no_frame", ready_cnt - r0, 0);
    check("brk_ferr_once", ferr_cnt - f0, 1);
    check("brk_perr", perr_cnt - p0, 0);
    check("brk_byte", rx_if.rx_byte, cur_byte);

    // back-to-back 01 then FF, then reset inside a third frame
    r0 = ready_cnt;
    send_frame(8'h01, 1'b1, 1'b0, t0);
    send_frame(8'hFF, 1'b1, 1'b0, t0);
    repeat (10) @(negedge tb_clk);
    check("b2b_count", ready_cnt - r0, 2);
    if (ready_bytes.size() >= 2) begin
      check("b2b_byte0", ready_bytes[ready_bytes.size()-2], 8'h01);
      check("b2b_byte1", ready_bytes[ready_bytes.size()-1], 8'hFF);
    end else begin
      check("b2b_bytes_seen", ready_bytes.size(), 2);
    end
    check("b2b_last_byte", rx_if.rx_byte, 8'hFF);

    r0 = ready_cnt; f0 = ferr_cnt;
    @(negedge tb_clk);
    rx_if.rx_serial = 1'b0;
    repeat (CPB * 4) @(negedge tb_clk);
    check("mid_busy", rx_if.rx_busy, 1'b1);
    nRst = 1'b0;
    @(negedge tb_clk);
    check("mid_rst_byte", rx_if.rx_byte, 8'h00);
    check("mid_rst_busy", rx_if.rx_busy, 1'b0);
    check("mid_rst_ready", rx_if.rx_ready, 1'b0);
    nRst = 1'b1;
    rx_if.rx_serial = 1'b1;
    repeat (CPB * 12) @(negedge tb_clk);
    check("mid_after_busy", rx_if.rx_busy, 1'b0);
    check("mid_after_pulses", (ready_cnt - r0) + (ferr_cnt - f0), 0);
    check("mid_after_byte", rx_if.rx_byte, 8'h00);

    check("exclusive_strobes", combo_bad, 0);
    if (!PAR_EN) check("perr_tied_low", perr_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
